// File: rtl/drink_dispenser_pkg.sv
// Shared definitions for the drink dispenser: FSM state encoding, drink codes
// and default phase lengths.
package drink_dispenser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CUP  = 3'd1,
        ST_HEAT = 3'd2,
        ST_POUR = 3'd3,
        ST_MILK = 3'd4,
        ST_FOAM = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    // Codes match the order FSM's selection codes
    typedef enum logic [1:0] {
        DRINK_NONE  = 2'b00,
        DRINK_EXPR  = 2'b01,
        DRINK_LATTE = 2'b10,
        DRINK_CAPP  = 2'b11
    } drink_t;

    localparam int unsigned DEF_CUP_CYC  = 2;
    localparam int unsigned DEF_HEAT_CYC = 4;
    localparam int unsigned DEF_POUR_CYC = 3;
    localparam int unsigned DEF_MILK_CYC = 2;
    localparam int unsigned DEF_FOAM_CYC = 2;

    // Simultaneous orders resolve capp > latte > expr
    function automatic drink_t pick_drink(input logic expr, input logic latte,
                                          input logic capp);
        if (capp)       return DRINK_CAPP;
        else if (latte) return DRINK_LATTE;
        else if (expr)  return DRINK_EXPR;
        else            return DRINK_NONE;
    endfunction

endpackage

// File: rtl/drink_dispenser_phase_timer.sv
// 8-bit loadable down-counter; expire flags the last cycle of a loaded phase.
module phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       expire
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    // A phase loaded with N expires on its N-th cycle
    assign expire = (r_cnt == 8'd1);

endmodule

// File: rtl/drink_dispenser.sv
// Beverage sequencer: cup, heat, pour, optional milk/foam, done; Moore outputs
// decoded from the state register, with a saturating served-drink counter.
module drink_dispenser
    import drink_dispenser_pkg::*;
#(
    parameter int unsigned CUP_CYC  = DEF_CUP_CYC,
    parameter int unsigned HEAT_CYC = DEF_HEAT_CYC,
    parameter int unsigned POUR_CYC = DEF_POUR_CYC,
    parameter int unsigned MILK_CYC = DEF_MILK_CYC,
    parameter int unsigned FOAM_CYC = DEF_FOAM_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_expr,
    input  logic       req_latte,
    input  logic       req_capp,
    output logic       busy,
    output logic       cup_drop,
    output logic       heater_on,
    output logic       pump_on,
    output logic       milk_on,
    output logic       foam_on,
    output logic       done,
    output logic [1:0] drink_id,
    output logic [7:0] served_cnt
);

    localparam logic [7:0] CUP_LEN  = 8'(CUP_CYC);
    localparam logic [7:0] HEAT_LEN = 8'(HEAT_CYC);
    localparam logic [7:0] POUR_LEN = 8'(POUR_CYC);
    localparam logic [7:0] MILK_LEN = 8'(MILK_CYC);
    localparam logic [7:0] FOAM_LEN = 8'(FOAM_CYC);

    state_t     r_state;
    state_t     w_next;
    drink_t     r_drink;
    drink_t     w_drink_nxt;
    logic [7:0] r_served;
    logic       w_load;
    logic [7:0] w_load_val;
    logic       w_expire;

    phase_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .expire   (w_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_drink  <= DRINK_NONE;
            r_served <= '0;
        end else begin
            r_state <= w_next;
            r_drink <= w_drink_nxt;
            if (r_state == ST_DONE && r_served != 8'hFF) begin
                r_served <= r_served + 8'd1;
            end
        end
    end

    // The timer is reloaded on every state entry, so its expire applies to the current phase
    always_comb begin
        w_next      = r_state;
        w_drink_nxt = r_drink;
        w_load      = 1'b0;
        w_load_val  = '0;
        cup_drop    = 1'b0;
        heater_on   = 1'b0;
        pump_on     = 1'b0;
        milk_on     = 1'b0;
        foam_on     = 1'b0;
        done        = 1'b0;
        busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (req_expr || req_latte || req_capp) begin
                    w_next      = ST_CUP;
                    w_drink_nxt = pick_drink(req_expr, req_latte, req_capp);
                    w_load      = 1'b1;
                    w_load_val  = CUP_LEN;
                end
            end
            ST_CUP: begin
                cup_drop = 1'b1;
                if (w_expire) begin
                    w_next     = ST_HEAT;
                    w_load     = 1'b1;
                    w_load_val = HEAT_LEN;
                end
            end
            ST_HEAT: begin
                heater_on = 1'b1;
                if (w_expire) begin
                    w_next     = ST_POUR;
                    w_load     = 1'b1;
                    w_load_val = POUR_LEN;
                end
            end
            ST_POUR: begin
                pump_on = 1'b1;
                if (w_expire) begin
                    w_load = 1'b1;
                    if (r_drink == DRINK_EXPR) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next     = ST_MILK;
                        w_load_val = MILK_LEN;
                    end
                end
            end
            ST_MILK: begin
                milk_on = 1'b1;
                if (w_expire) begin
                    w_load = 1'b1;
                    if (r_drink == DRINK_CAPP) begin
                        w_next     = ST_FOAM;
                        w_load_val = FOAM_LEN;
                    end else begin
                        w_next = ST_DONE;
                    end
                end
            end
            ST_FOAM: begin
                foam_on = 1'b1;
                if (w_expire) begin
                    w_next = ST_DONE;
                    w_load = 1'b1;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_next      = ST_IDLE;
                w_drink_nxt = DRINK_NONE;
            end
            default: begin
                w_next      = ST_IDLE;
                w_drink_nxt = DRINK_NONE;
            end
        endcase
    end

    assign drink_id   = r_drink;
    assign served_cnt = r_served;

endmodule

// File: tb/tb_drink_dispenser.sv
// Directed bench for drink_dispenser at default phase lengths.
module tb_drink_dispenser;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_expr;
    logic       req_latte;
    logic       req_capp;
    logic       busy;
    logic       cup_drop;
    logic       heater_on;
    logic       pump_on;
    logic       milk_on;
    logic       foam_on;
    logic       done;
    logic [1:0] drink_id;
    logic [7:0] served_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [4:0] A_NONE = 5'b00000;
    localparam logic [4:0] A_CUP  = 5'b10000;
    localparam logic [4:0] A_HEAT = 5'b01000;
    localparam logic [4:0] A_POUR = 5'b00100;
    localparam logic [4:0] A_MILK = 5'b00010;
    localparam logic [4:0] A_FOAM = 5'b00001;

    drink_dispenser dut (
        .clk        (clk),
        .rst        (rst),
        .req_expr   (req_expr),
        .req_latte  (req_latte),
        .req_capp   (req_capp),
        .busy       (busy),
        .cup_drop   (cup_drop),
        .heater_on  (heater_on),
        .pump_on    (pump_on),
        .milk_on    (milk_on),
        .foam_on    (foam_on),
        .done       (done),
        .drink_id   (drink_id),
        .served_cnt (served_cnt)
    );

    always #5 clk = ~clk;

    logic [8:0] w_obs;
    assign w_obs = {busy, cup_drop, heater_on, pump_on, milk_on, foam_on, done, drink_id};

    // Expected output vector: {busy, cup, heat, pump, milk, foam, done, drink_id}
    function automatic logic [8:0] ev(input logic [4:0] act, input logic dn,
                                      input logic [1:0] d);
        return {(act != 5'd0) || dn, act, dn, d};
    endfunction

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic order(input logic e, input logic l, input logic c);
        req_expr  = e;
        req_latte = l;
        req_capp  = c;
        tick();
        req_expr  = 1'b0;
        req_latte = 1'b0;
        req_capp  = 1'b0;
    endtask

    task automatic run_phase(input string tag, input int n, input logic [4:0] act,
                             input logic dn, input logic [1:0] d);
        for (int i = 0; i < n; i++) begin
            check(tag, w_obs, ev(act, dn, d));
            tick();
        end
    endtask

    initial begin
        rst       = 1'b0;
        req_expr  = 1'b0;
        req_latte = 1'b0;
        req_capp  = 1'b0;

        // Reset with a request held during reset
        req_capp = 1'b1;
        tick();
        tick();
        req_capp = 1'b0;
        check("rst_out", w_obs, 9'd0);
        check("rst_cnt", {1'b0, served_cnt}, 9'd0);
        rst = 1'b1;
        tick();
        check("rst_discard", w_obs, 9'd0);

        // Espresso: cup 1-2, heat 3-6, pump 7-9, done 10, idle 11
        order(1'b1, 1'b0, 1'b0);
        run_phase("exp_cup",  2, A_CUP,  1'b0, 2'b01);
        run_phase("exp_heat", 4, A_HEAT, 1'b0, 2'b01);
        run_phase("exp_pour", 3, A_POUR, 1'b0, 2'b01);
        run_phase("exp_done", 1, A_NONE, 1'b1, 2'b01);
        check("exp_idle", w_obs, 9'd0);
        check("exp_cnt", {1'b0, served_cnt}, 9'd1);

        // Busy: capp at cycle 5 ignored; latte coinciding with done ignored
        order(1'b1, 1'b0, 1'b0);
        run_phase("busy_cup",  2, A_CUP,  1'b0, 2'b01);
        run_phase("busy_heat", 2, A_HEAT, 1'b0, 2'b01);
        req_capp = 1'b1;
        run_phase("busy_heat5", 1, A_HEAT, 1'b0, 2'b01);
        req_capp = 1'b0;
        run_phase("busy_heat6", 1, A_HEAT, 1'b0, 2'b01);
        run_phase("busy_pour", 3, A_POUR, 1'b0, 2'b01);
        req_latte = 1'b1;
        run_phase("busy_done", 1, A_NONE, 1'b1, 2'b01);
        req_latte = 1'b0;
        check("busy_idle11", w_obs, 9'd0);
        check("busy_cnt", {1'b0, served_cnt}, 9'd2);
        tick();
        check("busy_idle12", w_obs, 9'd0);

        // Cappuccino: milk 10-11, foam 12-13, done 14
        order(1'b0, 1'b0, 1'b1);
        run_phase("cap_cup",  2, A_CUP,  1'b0, 2'b11);
        run_phase("cap_heat", 4, A_HEAT, 1'b0, 2'b11);
        run_phase("cap_pour", 3, A_POUR, 1'b0, 2'b11);
        run_phase("cap_milk", 2, A_MILK, 1'b0, 2'b11);
        run_phase("cap_foam", 2, A_FOAM, 1'b0, 2'b11);
        run_phase("cap_done", 1, A_NONE, 1'b1, 2'b11);
        check("cap_idle", w_obs, 9'd0);
        check("cap_cnt", {1'b0, served_cnt}, 9'd3);

        // Priority latte > expr: milk, no foam, done at 12
        order(1'b1, 1'b1, 1'b0);
        run_phase("pri_cup",  2, A_CUP,  1'b0, 2'b10);
        run_phase("pri_heat", 4, A_HEAT, 1'b0, 2'b10);
        run_phase("pri_pour", 3, A_POUR, 1'b0, 2'b10);
        run_phase("pri_milk", 2, A_MILK, 1'b0, 2'b10);
        run_phase("pri_done", 1, A_NONE, 1'b1, 2'b10);
        check("pri_idle", w_obs, 9'd0);
        check("pri_cnt", {1'b0, served_cnt}, 9'd4);

        // All three at once: cappuccino wins
        order(1'b1, 1'b1, 1'b1);
        run_phase("all_cup",  2, A_CUP,  1'b0, 2'b11);
        run_phase("all_heat", 4, A_HEAT, 1'b0, 2'b11);
        run_phase("all_pour", 3, A_POUR, 1'b0, 2'b11);
        run_phase("all_milk", 2, A_MILK, 1'b0, 2'b11);
        run_phase("all_foam", 2, A_FOAM, 1'b0, 2'b11);
        run_phase("all_done", 1, A_NONE, 1'b1, 2'b11);
        check("all_cnt", {1'b0, served_cnt}, 9'd5);

        // Reset at cycle 8 of a latte
        order(1'b0, 1'b1, 1'b0);
        run_phase("rl_cup",  2, A_CUP,  1'b0, 2'b10);
        run_phase("rl_heat", 4, A_HEAT, 1'b0, 2'b10);
        run_phase("rl_pour", 1, A_POUR, 1'b0, 2'b10);
        check("rl_pour8", w_obs, ev(A_POUR, 1'b0, 2'b10));
        rst = 1'b0;
        tick();
        check("rl_out", w_obs, 9'd0);
        check("rl_cnt", {1'b0, served_cnt}, 9'd0);
        rst = 1'b1;
        run_phase("rl_idle", 4, A_NONE, 1'b0, 2'b00);
        check("rl_cnt_after", {1'b0, served_cnt}, 9'd0);

        // Saturation: 256 espressos leave served_cnt at 255
        for (int k = 0; k < 255; k++) begin
            order(1'b1, 1'b0, 1'b0);
            repeat (10) tick();
        end
        check("sat_255", {1'b0, served_cnt}, 9'd255);
        order(1'b1, 1'b0, 1'b0);
        run_phase("sat_cup",  2, A_CUP,  1'b0, 2'b01);
        run_phase("sat_heat", 4, A_HEAT, 1'b0, 2'b01);
        run_phase("sat_pour", 3, A_POUR, 1'b0, 2'b01);
        run_phase("sat_done", 1, A_NONE, 1'b1, 2'b01);
        check("sat_idle", w_obs, 9'd0);
        check("sat_hold", {1'b0, served_cnt}, 9'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/drink_dispenser.md
DRINK_DISPENSER -- requirements
Module: drink_dispenser

Interface
REQ-001 Parameter CUP_CYC, default 2, cycles the cup_drop phase lasts (legal 1..255).
REQ-002 Parameter HEAT_CYC, default 4, cycles the heater phase lasts (legal 1..255).
REQ-003 Parameter POUR_CYC, default 3, cycles the coffee-pump phase lasts (legal 1..255).
REQ-004 Parameter MILK_CYC, default 2, cycles the milk phase lasts (legal 1..255).
REQ-005 Parameter FOAM_CYC, default 2, cycles the foam phase lasts (legal 1..255).
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset; synchronous and active-low.
REQ-008 req_expr  input  1  single-cycle espresso order pulse from the order FSM.
REQ-009 req_latte  input  1  single-cycle latte order pulse.
REQ-010 req_capp  input  1  single-cycle cappuccino order pulse.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 cup_drop, heater_on, pump_on, milk_on, foam_on  output  1 each  actuator enables.
REQ-013 done  output  1  single-cycle completion pulse.
REQ-014 drink_id  output  2  drink being made: 00 none, 01 espresso, 10 latte, 11 cappuccino.
REQ-015 served_cnt  output  8  count of completed drinks.

Function
REQ-016 FSM states SHALL be IDLE, CUP, HEAT, POUR, MILK, FOAM, DONE.
REQ-017 In IDLE, a request sampled high at edge t SHALL enter CUP at t+1 and latch drink_id.
REQ-018 Simultaneous requests SHALL resolve by priority capp > latte > expr.
REQ-019 Requests arriving while busy is high SHALL be ignored with no queuing.
REQ-020 Each timed state SHALL last exactly its parameter in cycles, counted by a down-counter loaded on entry.
REQ-021 Sequence: espresso CUP->HEAT->POUR->DONE; latte adds MILK after POUR; cappuccino adds MILK then FOAM.
REQ-022 DONE SHALL last exactly one cycle, assert done, then return to IDLE.
REQ-023 Outputs SHALL be Moore-decoded from the state register: cup_drop in CUP, heater_on in HEAT, pump_on in POUR, milk_on in MILK, foam_on in FOAM.
REQ-024 At most one actuator enable SHALL be high in any cycle.
REQ-025 drink_id SHALL hold the latched value from CUP through DONE and read 00 in IDLE.
REQ-026 served_cnt SHALL increment on the edge leaving DONE and saturate at 255 (no wrap).
REQ-027 A request in the same cycle as done SHALL be ignored; the earliest accepted request is in the following IDLE cycle.

Reset
REQ-028 When rst is low at a rising edge, the block SHALL enter IDLE on that edge, with the phase counter at 0, drink_id 00 and served_cnt 0.
REQ-029 After that edge all outputs SHALL read 0.
REQ-030 A reset mid-drink SHALL abort immediately, with no done pulse and no served_cnt increment.
REQ-031 Requests sampled while rst is low SHALL be discarded.

Structure
REQ-032 A shared package SHALL hold the state encoding (3 bits), the drink_id codes (01/10/11, matching the order-FSM selection codes) and the default phase lengths.
REQ-033 The phase timer SHALL be a sub-module phase_timer: 8-bit loadable down-counter with a load input and an expire output.

Verification (defaults assumed)
REQ-034 Espresso test: req_expr pulse at cycle 0 SHALL give cup_drop for cycles 1-2, heater_on for 3-6, pump_on for 7-9, done at 10, IDLE at 11, and served_cnt = 1.
REQ-035 Cappuccino test: req_capp SHALL give milk_on for cycles 10-11, foam_on for 12-13, done at 14, and drink_id 11 throughout.
REQ-036 Priority test: req_latte and req_expr high in the same cycle SHALL latch drink_id 10 and run MILK, with no FOAM.
REQ-037 Busy test: req_capp at cycle 5 of an espresso SHALL be ignored (done at 10 only, served_cnt +1), and a request coinciding with done SHALL also be ignored.
REQ-038 Reset test: rst low at cycle 8 of a latte SHALL put all outputs at 0 on the next cycle, with served_cnt 0 and no done pulse.
REQ-039 Saturation test: 256 espresso orders SHALL leave served_cnt at 255.
